// File: rtl/ham_secded_codec.sv
// rtl/ham_secded_codec.sv - SECDED Hamming codec: 1-stage encoder, 2-stage decoder, saturating error counters
module ham_secded_codec #(
  parameter int  DATA_W = 11,
  parameter int  CNT_W  = 16,
  localparam int PAR_W  = (DATA_W <= 4) ? 3 : (DATA_W <= 11) ? 4 : (DATA_W <= 26) ? 5 : 6,
  localparam int CODE_W = DATA_W + PAR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [DATA_W-1:0] enc_data_i,
  input  logic              enc_valid_i,
  output logic              enc_ready_o,
  output logic [CODE_W-1:0] enc_code_o,
  output logic              enc_valid_o,
  input  logic              enc_ready_i,
  input  logic [CODE_W-1:0] dec_code_i,
  input  logic              dec_valid_i,
  output logic              dec_ready_o,
  output logic [DATA_W-1:0] dec_data_o,
  output logic              dec_valid_o,
  input  logic              dec_ready_i,
  output logic              dec_corr_o,
  output logic              dec_uncorr_o,
  output logic [PAR_W-1:0]  dec_syn_o,
  input  logic              cnt_clr_i,
  output logic [CNT_W-1:0]  corr_cnt_o,
  output logic [CNT_W-1:0]  uncorr_cnt_o
);

  // Hamming position pos lives at bit pos-1; powers of two hold parity, the MSB holds overall parity.
  function automatic logic [CODE_W-1:0] f_encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    logic              p;
    int                k;
    c = '0;
    k = 0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[k];
        k++;
      end
    end
    for (int i = 0; i < PAR_W; i++) begin
      p = 1'b0;
      for (int pos = 1; pos < CODE_W; pos++)
        if (((pos >> i) & 1) != 0) p = p ^ c[pos-1];
      c[(1 << i) - 1] = p;
    end
    c[CODE_W-1] = ^c[CODE_W-2:0];
    return c;
  endfunction

  function automatic logic [PAR_W-1:0] f_syndrome(input logic [CODE_W-2:0] c);
    logic [PAR_W-1:0] s;
    s = '0;
    for (int i = 0; i < PAR_W; i++)
      for (int pos = 1; pos < CODE_W; pos++)
        if (((pos >> i) & 1) != 0) s[i] = s[i] ^ c[pos-1];
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] f_extract(input logic [CODE_W-2:0] c);
    logic [DATA_W-1:0] d;
    int                k;
    d = '0;
    k = 0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[k] = c[pos-1];
        k++;
      end
    end
    return d;
  endfunction

  logic              r_enc_valid;
  logic [CODE_W-1:0] r_enc_code;
  logic              r_s1_valid;
  logic [CODE_W-2:0] r_s1_code;
  logic [PAR_W-1:0]  r_s1_syn;
  logic              r_s1_q;
  logic              r_s2_valid;
  logic [DATA_W-1:0] r_s2_data;
  logic              r_s2_corr;
  logic              r_s2_uncorr;
  logic [PAR_W-1:0]  r_s2_syn;
  logic [CNT_W-1:0]  r_corr_cnt;
  logic [CNT_W-1:0]  r_uncorr_cnt;

  logic              w_enc_ready;
  logic              w_en;
  logic              w_dec_hs;
  logic [CODE_W-2:0] w_fixed;
  logic              w_pos_ok;
  logic              w_corr;
  logic              w_uncorr;

  assign w_enc_ready = !r_enc_valid || enc_ready_i;
  assign w_en        = !r_s2_valid || dec_ready_i;
  assign w_dec_hs    = r_s2_valid && dec_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_enc_valid <= 1'b0;
      r_enc_code  <= '0;
    end else if (w_enc_ready) begin
      r_enc_valid <= enc_valid_i;
      if (enc_valid_i) r_enc_code <= f_encode(enc_data_i);
    end
  end

  // w_pos_ok: syndrome names a real bit (or zero); larger syndromes cannot come from one flip.
  always_comb begin
    w_fixed  = r_s1_code;
    w_pos_ok = (r_s1_syn == '0);
    for (int pos = 1; pos < CODE_W; pos++) begin
      if (int'(r_s1_syn) == pos) begin
        w_pos_ok = 1'b1;
        if (r_s1_q) w_fixed[pos-1] = ~r_s1_code[pos-1];
      end
    end
    w_corr   = r_s1_q && w_pos_ok;
    w_uncorr = r_s1_q ? !w_pos_ok : (r_s1_syn != '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_s1_valid  <= 1'b0;
      r_s1_code   <= '0;
      r_s1_syn    <= '0;
      r_s1_q      <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_data   <= '0;
      r_s2_corr   <= 1'b0;
      r_s2_uncorr <= 1'b0;
      r_s2_syn    <= '0;
    end else if (w_en) begin
      r_s1_valid <= dec_valid_i;
      if (dec_valid_i) begin
        r_s1_code <= dec_code_i[CODE_W-2:0];
        r_s1_syn  <= f_syndrome(dec_code_i[CODE_W-2:0]);
        r_s1_q    <= ^dec_code_i;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data   <= f_extract(w_fixed);
        r_s2_corr   <= w_corr;
        r_s2_uncorr <= w_uncorr;
        r_s2_syn    <= r_s1_syn;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || cnt_clr_i) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (w_dec_hs) begin
      if (r_s2_corr && r_corr_cnt != {CNT_W{1'b1}})     r_corr_cnt   <= r_corr_cnt + 1'b1;
      if (r_s2_uncorr && r_uncorr_cnt != {CNT_W{1'b1}}) r_uncorr_cnt <= r_uncorr_cnt + 1'b1;
    end
  end

  assign enc_ready_o  = w_enc_ready;
  assign enc_valid_o  = r_enc_valid;
  assign enc_code_o   = r_enc_code;
  assign dec_ready_o  = w_en;
  assign dec_valid_o  = r_s2_valid;
  assign dec_data_o   = r_s2_data;
  assign dec_corr_o   = r_s2_corr;
  assign dec_uncorr_o = r_s2_uncorr;
  assign dec_syn_o    = r_s2_syn;
  assign corr_cnt_o   = r_corr_cnt;
  assign uncorr_cnt_o = r_uncorr_cnt;

endmodule

// File: tb/tb_ham_secded_codec.sv
// tb/tb_ham_secded_codec.sv - randomized scoreboard bench for ham_secded_codec
module tb_ham_secded_codec;
  localparam int DW = 11, CW = 16, PW = 4, CNTW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n_i, enc_valid_i, enc_ready_i, dec_valid_i, dec_ready_i, cnt_clr_i;
  logic [DW-1:0]   enc_data_i, dec_data_o;
  logic [CW-1:0]   dec_code_i, enc_code_o;
  logic            enc_ready_o, enc_valid_o, dec_ready_o, dec_valid_o, dec_corr_o, dec_uncorr_o;
  logic [PW-1:0]   dec_syn_o;
  logic [CNTW-1:0] corr_cnt_o, uncorr_cnt_o;

  ham_secded_codec #(.DATA_W(DW), .CNT_W(CNTW)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .enc_data_i(enc_data_i), .enc_valid_i(enc_valid_i), .enc_ready_o(enc_ready_o),
    .enc_code_o(enc_code_o), .enc_valid_o(enc_valid_o), .enc_ready_i(enc_ready_i),
    .dec_code_i(dec_code_i), .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_data_o(dec_data_o), .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
    .dec_corr_o(dec_corr_o), .dec_uncorr_o(dec_uncorr_o), .dec_syn_o(dec_syn_o),
    .cnt_clr_i(cnt_clr_i), .corr_cnt_o(corr_cnt_o), .uncorr_cnt_o(uncorr_cnt_o)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          corr;
    logic          uncorr;
    logic [PW-1:0] syn;
  } dres_t;

  int n_pass = 0, n_tot = 0, cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // A valid codeword has the XOR of the positions of all its set bits equal to zero.
  function automatic logic [CW-1:0] m_enc(input logic [DW-1:0] d);
    logic [CW-1:0] c;
    int k, x;
    c = '0; k = 0; x = 0;
    for (int pos = 1; pos < CW; pos++)
      if ((pos & (pos - 1)) != 0) begin c[pos-1] = d[k]; k++; end
    for (int pos = 1; pos < CW; pos++) if (c[pos-1]) x = x ^ pos;
    for (int i = 0; i < PW; i++) c[(1 << i) - 1] = x[i];
    c[CW-1] = ^c[CW-2:0];
    return c;
  endfunction

  function automatic dres_t m_dec(input logic [CW-1:0] c);
    dres_t r;
    logic [CW-1:0] f;
    int s, k;
    s = 0; f = c;
    for (int pos = 1; pos < CW; pos++) if (c[pos-1]) s = s ^ pos;
    r.corr = 1'b0; r.uncorr = 1'b0;
    if (^c) begin
      if (s < CW) begin
        r.corr = 1'b1;
        if (s != 0) f[s-1] = ~f[s-1];
      end else r.uncorr = 1'b1;
    end else if (s != 0) r.uncorr = 1'b1;
    r.data = '0; k = 0;
    for (int pos = 1; pos < CW; pos++)
      if ((pos & (pos - 1)) != 0) begin r.data[k] = f[pos-1]; k++; end
    r.syn = s[PW-1:0];
    return r;
  endfunction

  function automatic logic [CW-1:0] rand_code(input int nerr);
    logic [CW-1:0] c;
    int b1, b2;
    c  = m_enc(DW'($urandom));
    b1 = $urandom_range(0, CW - 1);
    b2 = (b1 + 1 + $urandom_range(0, CW - 2)) % CW;
    if (nerr >= 1) c[b1] = ~c[b1];
    if (nerr >= 2) c[b2] = ~c[b2];
    if (nerr >= 3) c = CW'($urandom);
    return c;
  endfunction

  logic [CW-1:0]   enc_q[$];
  int              enc_t[$];
  dres_t           dec_q[$];
  int              dec_t[$];
  logic [CNTW-1:0] m_corr, m_uncorr;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n_i) begin
      enc_q.delete(); enc_t.delete(); dec_q.delete(); dec_t.delete();
      m_corr = '0; m_uncorr = '0;
    end else begin
      chk("enc_ready_rule", enc_ready_o, !enc_valid_o || enc_ready_i);
      chk("dec_ready_rule", dec_ready_o, !dec_valid_o || dec_ready_i);
      if (enc_valid_o) begin
        if (enc_q.size() == 0) chk("enc_phantom", 0, 1);
        else begin
          chk("enc_code", enc_code_o, enc_q[0]);
          if (enc_ready_i) begin void'(enc_q.pop_front()); void'(enc_t.pop_front()); end
        end
      end else if (enc_q.size() > 0 && enc_t[0] + 1 <= cyc) chk("enc_missing", enc_valid_o, 1);
      chk("corr_cnt", corr_cnt_o, m_corr);
      chk("uncorr_cnt", uncorr_cnt_o, m_uncorr);
      if (dec_valid_o) begin
        if (dec_q.size() == 0) chk("dec_phantom", 0, 1);
        else begin
          chk("dec_latency", cyc >= dec_t[0] + 2, 1);
          chk("dec_data", dec_data_o, dec_q[0].data);
          chk("dec_corr", dec_corr_o, dec_q[0].corr);
          chk("dec_uncorr", dec_uncorr_o, dec_q[0].uncorr);
          chk("dec_syn", dec_syn_o, dec_q[0].syn);
          if (dec_ready_i) begin
            if (!cnt_clr_i && dec_q[0].corr && m_corr != '1) m_corr = m_corr + 1'b1;
            if (!cnt_clr_i && dec_q[0].uncorr && m_uncorr != '1) m_uncorr = m_uncorr + 1'b1;
            void'(dec_q.pop_front()); void'(dec_t.pop_front());
          end
        end
      end else if (dec_q.size() > 0 && dec_t[0] + 2 <= cyc) chk("dec_missing", dec_valid_o, 1);
      if (cnt_clr_i) begin m_corr = '0; m_uncorr = '0; end
      if (enc_valid_i && enc_ready_o) begin enc_q.push_back(m_enc(enc_data_i)); enc_t.push_back(cyc); end
      if (dec_valid_i && dec_ready_o) begin dec_q.push_back(m_dec(dec_code_i)); dec_t.push_back(cyc); end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  dres_t r0;

  initial begin
    rst_n_i = 1'b0; enc_valid_i = 1'b0; enc_ready_i = 1'b0; enc_data_i = '0;
    dec_valid_i = 1'b0; dec_ready_i = 1'b0; dec_code_i = '0; cnt_clr_i = 1'b0;

    chk("model_enc_000", m_enc(11'h000), 16'h0000);
    chk("model_enc_7ff", m_enc(11'h7FF), 16'hFFFF);
    chk("model_enc_001", m_enc(11'h001), 16'h8007);
    r0 = m_dec(16'h8027);
    chk("model_dec_8027", {r0.data, r0.corr, r0.uncorr, r0.syn}, {11'h001, 1'b1, 1'b0, 4'd6});
    r0 = m_dec(16'h8037);
    chk("model_dec_8037", {r0.corr, r0.uncorr, r0.syn}, {1'b0, 1'b1, 4'd3});

    tick(); tick();
    rst_n_i = 1'b1;
    chk("rst_enc_valid", enc_valid_o, 0);
    chk("rst_dec_valid", dec_valid_o, 0);
    chk("rst_enc_ready", enc_ready_o, 1);
    chk("rst_dec_ready", dec_ready_o, 1);
    chk("rst_counters", {corr_cnt_o, uncorr_cnt_o}, 0);

    // Back-to-back encode.
    enc_ready_i = 1'b1; enc_valid_i = 1'b1; enc_data_i = 11'h000;
    tick(); chk("enc_lit_0", {enc_valid_o, enc_code_o}, {1'b1, 16'h0000});
    enc_data_i = 11'h7FF;
    tick(); chk("enc_lit_1", {enc_valid_o, enc_code_o}, {1'b1, 16'hFFFF});
    enc_data_i = 11'h001;
    tick(); chk("enc_lit_2", {enc_valid_o, enc_code_o}, {1'b1, 16'h8007});
    enc_valid_i = 1'b0;
    tick(); chk("enc_lit_idle", enc_valid_o, 0);

    // Clean, single-bit and overall-parity decodes.
    dec_ready_i = 1'b1; dec_valid_i = 1'b1; dec_code_i = 16'h8007;
    tick(); dec_code_i = 16'h8027;
    tick(); chk("dec_lit_8007", {dec_valid_o, dec_data_o, dec_corr_o, dec_uncorr_o, dec_syn_o}, {1'b1, 11'h001, 1'b0, 1'b0, 4'd0});
    dec_code_i = 16'h0007;
    tick(); chk("dec_lit_8027", {dec_valid_o, dec_data_o, dec_corr_o, dec_uncorr_o, dec_syn_o}, {1'b1, 11'h001, 1'b1, 1'b0, 4'd6});
    dec_valid_i = 1'b0;
    tick(); chk("dec_lit_0007", {dec_valid_o, dec_data_o, dec_corr_o, dec_uncorr_o, dec_syn_o}, {1'b1, 11'h001, 1'b1, 1'b0, 4'd0});
    tick(); chk("dec_lit_corr_cnt", corr_cnt_o, 2);

    // Double error.
    dec_valid_i = 1'b1; dec_code_i = 16'h8037;
    tick(); dec_valid_i = 1'b0;
    tick(); chk("dec_lit_8037", {dec_valid_o, dec_corr_o, dec_uncorr_o, dec_syn_o}, {1'b1, 1'b0, 1'b1, 4'd3});
    tick(); chk("dec_lit_uncorr_cnt", uncorr_cnt_o, 1);

    // Output stall with three words offered.
    r0 = m_dec(16'h8027);
    dec_ready_i = 1'b0; dec_valid_i = 1'b1; dec_code_i = 16'h8027;
    tick(); dec_code_i = rand_code(1);
    tick(); chk("stall_ready_low", dec_ready_o, 0);
    dec_code_i = rand_code(0);
    repeat (3) begin
      tick();
      chk("stall_ready_held", dec_ready_o, 0);
      chk("stall_data_held", {dec_valid_o, dec_data_o}, {1'b1, r0.data});
    end
    dec_ready_i = 1'b1;
    tick(); dec_valid_i = 1'b0;
    repeat (4) tick();

    // Saturation, then clear against a simultaneous counted handshake.
    cnt_clr_i = 1'b1;
    tick(); cnt_clr_i = 1'b0;
    chk("clr_corr_cnt", corr_cnt_o, 0);
    dec_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin dec_code_i = rand_code(1); tick(); end
    dec_valid_i = 1'b0;
    repeat (3) tick();
    chk("sat_corr_cnt", corr_cnt_o, 3);
    dec_valid_i = 1'b1; dec_code_i = rand_code(1);
    tick(); dec_valid_i = 1'b0;
    tick(); chk("clr_hs_word", {dec_valid_o, dec_corr_o}, 2'b11);
    cnt_clr_i = 1'b1;
    tick(); cnt_clr_i = 1'b0;
    chk("clr_wins", corr_cnt_o, 0);

    // Mid-stream reset with both channels full.
    dec_valid_i = 1'b1;
    for (int i = 0; i < 2; i++) begin dec_code_i = rand_code(1); tick(); end
    dec_valid_i = 1'b0;
    repeat (3) tick();
    enc_ready_i = 1'b0; dec_ready_i = 1'b0; enc_valid_i = 1'b1; dec_valid_i = 1'b1;
    enc_data_i = DW'($urandom); dec_code_i = rand_code(1);
    repeat (3) tick();
    chk("prereset_full", {enc_valid_o, dec_valid_o, corr_cnt_o != 0}, 3'b111);
    rst_n_i = 1'b0;
    tick();
    chk("midrst_valids", {enc_valid_o, dec_valid_o}, 0);
    chk("midrst_flags", {dec_corr_o, dec_uncorr_o, dec_syn_o}, 0);
    chk("midrst_counters", {corr_cnt_o, uncorr_cnt_o}, 0);
    chk("midrst_data", {enc_code_o, dec_data_o}, 0);
    rst_n_i = 1'b1; enc_valid_i = 1'b0; dec_valid_i = 1'b0;
    chk("postrst_ready", {enc_ready_o, dec_ready_o}, 2'b11);
    enc_ready_i = 1'b1; dec_ready_i = 1'b1;
    repeat (4) begin tick(); chk("postrst_no_stale", {enc_valid_o, dec_valid_o}, 0); end

    // Randomized traffic on both channels.
    for (int i = 0; i < 2000; i++) begin
      enc_valid_i = ($urandom_range(0, 3) != 0);
      enc_data_i  = DW'($urandom);
      enc_ready_i = ($urandom_range(0, 3) != 0);
      dec_valid_i = ($urandom_range(0, 3) != 0);
      dec_code_i  = rand_code($urandom_range(0, 3));
      dec_ready_i = ($urandom_range(0, 3) != 0);
      cnt_clr_i   = ($urandom_range(0, 63) == 0);
      rst_n_i     = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst_n_i = 1'b1; enc_valid_i = 1'b0; dec_valid_i = 1'b0;
    enc_ready_i = 1'b1; dec_ready_i = 1'b1; cnt_clr_i = 1'b0;
    repeat (5) tick();
    chk("drain_enc", enc_q.size(), 0);
    chk("drain_dec", dec_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
